// File: rtl/dm_arbiter.sv
// Two-port arbiter for the shared single-port data memory (port C = CPU, port D = DMA/debug).
// Define DM_ARB_RR_EN for round-robin tie breaking; otherwise ties go to port C.
module dm_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_lock,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [15:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_lock,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        mem_wflag,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {OwnNone, OwnC, OwnD} owner_e;

    owner_e      r_owner, w_owner_nxt;
    logic [3:0]  r_burst, w_burst_nxt;
    logic        w_gnt_c, w_gnt_d, w_burst_ok;
    logic        r_c_rvalid, r_d_rvalid;
    logic [15:0] r_c_rdata, r_d_rdata;
`ifdef DM_ARB_RR_EN
    logic        r_last_d;
`endif

    assign w_burst_ok = (r_burst < 4'(MAX_BURST));

    always_comb begin
        w_gnt_c = 1'b0;
        w_gnt_d = 1'b0;
        if (rst) begin
            w_gnt_c = 1'b0;
        end else if (r_owner == OwnC && c_req && (!d_req || w_burst_ok)) begin
            w_gnt_c = 1'b1;
        end else if (r_owner == OwnD && d_req && (!c_req || w_burst_ok)) begin
            w_gnt_d = 1'b1;
        end else if (c_req && !d_req) begin
            w_gnt_c = 1'b1;
        end else if (d_req && !c_req) begin
            w_gnt_d = 1'b1;
        end else if (c_req && d_req) begin
            // A locked owner reaching here has exhausted its burst: hand one slot to the other port
            if (r_owner == OwnC) begin
                w_gnt_d = 1'b1;
            end else if (r_owner == OwnD) begin
                w_gnt_c = 1'b1;
            end else begin
`ifdef DM_ARB_RR_EN
                w_gnt_c = r_last_d;
                w_gnt_d = ~r_last_d;
`else
                w_gnt_c = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        if (w_gnt_c) begin
            if (c_lock) begin
                w_owner_nxt = OwnC;
                if (r_owner == OwnC) begin
                    w_burst_nxt = (r_burst == 4'hF) ? 4'hF : r_burst + 4'd1;
                end else begin
                    w_burst_nxt = 4'd1;
                end
            end else begin
                w_owner_nxt = OwnNone;
                w_burst_nxt = 4'd0;
            end
        end else if (w_gnt_d) begin
            if (d_lock) begin
                w_owner_nxt = OwnD;
                if (r_owner == OwnD) begin
                    w_burst_nxt = (r_burst == 4'hF) ? 4'hF : r_burst + 4'd1;
                end else begin
                    w_burst_nxt = 4'd1;
                end
            end else begin
                w_owner_nxt = OwnNone;
                w_burst_nxt = 4'd0;
            end
        end else begin
            w_owner_nxt = OwnNone;
            w_burst_nxt = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OwnNone;
            r_burst    <= 4'd0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= 16'h0000;
            r_d_rdata  <= 16'h0000;
        end else begin
            r_owner    <= w_owner_nxt;
            r_burst    <= w_burst_nxt;
            r_c_rvalid <= w_gnt_c & ~c_we;
            r_d_rvalid <= w_gnt_d & ~d_we;
            if (w_gnt_c && !c_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (w_gnt_d && !d_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

`ifdef DM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (w_gnt_c || w_gnt_d) begin
            r_last_d <= w_gnt_d;
        end
    end
`endif

    assign c_gnt     = w_gnt_c;
    assign d_gnt     = w_gnt_d;
    assign c_rvalid  = r_c_rvalid & ~rst;
    assign d_rvalid  = r_d_rvalid & ~rst;
    assign c_rdata   = r_c_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_wflag = (w_gnt_c & c_we) | (w_gnt_d & d_we);
    assign mem_addr  = w_gnt_c ? c_addr : (w_gnt_d ? d_addr : 16'h0000);
    assign mem_wdata = w_gnt_c ? c_wdata : (w_gnt_d ? d_wdata : 16'h0000);

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter sharing the single-port 16-bit data memory between the processor load/store path (port C) and a DMA/debug master (port D). Each cycle it selects at most one requester, drives the memory's write flag, address and write data from that requester, and returns registered read data one cycle later. Bounded burst locking lets a master perform back-to-back accesses without starving the other port.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive grants to one locked port while the other port is requesting (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  port C access request
- c_we  in  1  port C write enable (1 = write, 0 = read)
- c_lock  in  1  port C requests to retain ownership after this access
- c_addr  in  16  port C word address
- c_wdata  in  16  port C write data
- c_gnt  out  1  port C access performed this cycle
- c_rvalid  out  1  port C read data valid
- c_rdata  out  16  port C read data
- d_req, d_we, d_lock, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as port C, for port D
- mem_wflag  out  1  memory write flag
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  combinational memory read data at mem_addr

## Operation
- Owner state: NONE, OWN_C, OWN_D. Registers: owner, last (last port granted), burst count (4 bits), rdata, rvalid per port.
- Grant decision is combinational from current requests and registered state:
  - owner = OWN_x and x_req = 1 and (other port idle or burst count < MAX_BURST): grant x.
  - Otherwise, only one port requesting: grant it.
  - Both requesting: arbitration policy (see Configuration).
  - Neither requesting: no grant.
- Granted port: x_gnt = 1; mem_addr = x_addr, mem_wdata = x_wdata, mem_wflag = x_we. No grant: mem_wflag = 0, mem_addr = 0, mem_wdata = 0. Both gnt never high together.
- Requester holds req/we/addr/wdata/lock stable until it sees gnt; the access completes in the gnt cycle.
- Granted read: mem_rdata captured into x_rdata at end of the gnt cycle; x_rvalid = 1 for exactly the next cycle. x_rdata holds its value until the next read grant to x. Writes produce no rvalid.
- Ownership update at clock edge: granted with x_lock = 1 -> owner = OWN_x; granted with x_lock = 0, or owner port drops req -> owner = NONE. last = granted port.
- Burst count: increments on a grant to the current owner (saturates at 15); resets to 1 when ownership is newly taken, to 0 when owner becomes NONE. When count reaches MAX_BURST and the other port requests, the other port is granted for one cycle and ownership is cleared; the locked port must re-arbitrate.

## Timing
- Reset: c_gnt, d_gnt, c_rvalid, d_rvalid = 0; c_rdata, d_rdata = 0; owner = NONE; burst = 0; last = D (port C wins first tie under round-robin); mem_wflag = 0, mem_addr = 0, mem_wdata = 0.
- Grant latency: 0 cycles (gnt in same cycle as req when selected). Read latency: rvalid one cycle after gnt.
- Back-to-back grants to one port sustain one access per cycle; read in cycle N and write in N+1 to same address: rdata returns pre-write value.
- rst asserted mid-burst: ownership and counters cleared at that edge; no gnt or rvalid in reset cycles; a pending rvalid is dropped.

## Configuration
- DM_ARB_RR_EN defined: tie between ports without ownership goes to the port not equal to last (round-robin).
- Not defined: ties always go to port C (fixed priority); locking and MAX_BURST limit unchanged.

## Test plan
- Reset then c_req=1, c_we=1, c_addr=0x0010, c_wdata=0xBEEF -> c_gnt=1 same cycle, mem_wflag=1; next cycle c read of 0x0010 -> c_rvalid=1 following cycle with c_rdata=0xBEEF.
- Both ports request reads continuously, no lock, RR enabled -> grants alternate C,D,C,D; fixed priority build -> C granted every cycle.
- d_lock=1 with continuous d_req, c_req=1, MAX_BURST=4 -> d_gnt 4 cycles, c_gnt 1 cycle, then D re-arbitrates.
- Lock held, other port idle -> owner granted beyond MAX_BURST (10 consecutive grants), no forced release.
- Write 0x1234 to 0x0005 then read 0x0005 from port D -> d_rdata=0x1234; concurrent c read in same cycle waits, no c_rvalid until its own grant.
- rst pulsed during locked D burst with pending read -> no d_rvalid after reset, owner NONE, next tie goes to C.
